// File: rtl/bcam_pkg.sv
// Shared types for the binary CAM controller.
// FSM state encoding and round-robin grant selectors.
package bcam_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WRITE  = 3'd1,
        ST_SEARCH = 3'd2,
        ST_RESULT = 3'd3,
        ST_CLEAR  = 3'd4
    } state_e;

    // Which client wins the next wr/srch collision.
    typedef enum logic {
        GNT_WR   = 1'b0,
        GNT_SRCH = 1'b1
    } rr_e;

endpackage

// File: rtl/bcam_prio_enc.sv
// Match-line priority encoder: hit flag, lowest set index, multi-hit flag.
// Purely combinational.
module bcam_prio_enc
    import bcam_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0]  match,
    output logic              hit,
    output logic [ADDR_W-1:0] addr,
    output logic              multi
);

    logic [DEPTH-1:0] one;

    assign one = {{(DEPTH-1){1'b0}}, 1'b1};

    always_comb begin
        hit   = |match;
        addr  = '0;
        // Clearing the lowest set bit leaves something only if two or more were set.
        multi = |(match & (match - one));
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (match[i]) begin
                addr = ADDR_W'(i);
            end
        end
    end

endmodule

// File: rtl/bcam_controller.sv
// Binary CAM sequencer: arbitrates write/search/clear onto the shared array bus,
// tracks per-entry validity and reports prioritised search results.
module bcam_controller
    import bcam_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int WIDTH  = 8,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    output logic              wr_ack,
    input  logic              srch_req,
    input  logic [WIDTH-1:0]  srch_key,
    output logic              srch_ack,
    output logic              srch_hit,
    output logic [ADDR_W-1:0] srch_addr,
    output logic              srch_multi,
    input  logic              clr_req,
    output logic              clr_ack,
    output logic              busy,
    output logic [DEPTH-1:0]  cam_we,
    output logic [WIDTH-1:0]  cam_bus,
    output logic              cam_rst,
    input  logic [DEPTH-1:0]  cam_match
);

    state_e            state_q, state_d;
    rr_e               rr_q, rr_d;
    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [DEPTH-1:0]  match_q, match_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [WIDTH-1:0]  opnd_q, opnd_d;
    logic              hit_q, hit_d;
    logic [ADDR_W-1:0] raddr_q, raddr_d;
    logic              multi_q, multi_d;

    logic              enc_hit;
    logic [ADDR_W-1:0] enc_addr;
    logic              enc_multi;
    logic [DEPTH-1:0]  wr_onehot;

    // Out-of-range addresses shift the bit off the top, so no row is enabled.
    assign wr_onehot = {{(DEPTH-1){1'b0}}, 1'b1} << addr_q;

    bcam_prio_enc #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_enc (
        .match (match_q),
        .hit   (enc_hit),
        .addr  (enc_addr),
        .multi (enc_multi)
    );

    always_comb begin
        state_d  = state_q;
        rr_d     = rr_q;
        valid_d  = valid_q;
        match_d  = match_q;
        addr_d   = addr_q;
        opnd_d   = opnd_q;
        hit_d    = hit_q;
        raddr_d  = raddr_q;
        multi_d  = multi_q;
        wr_ack   = 1'b0;
        srch_ack = 1'b0;
        clr_ack  = 1'b0;
        cam_we   = '0;
        cam_bus  = '0;
        cam_rst  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (clr_req) begin
                    state_d = ST_CLEAR;
                end else if (wr_req && (!srch_req || rr_q == GNT_WR)) begin
                    state_d = ST_WRITE;
                    addr_d  = wr_addr;
                    opnd_d  = wr_data;
                    rr_d    = GNT_SRCH;
                end else if (srch_req) begin
                    state_d = ST_SEARCH;
                    opnd_d  = srch_key;
                    rr_d    = GNT_WR;
                end
            end
            ST_WRITE: begin
                cam_we  = wr_onehot;
                cam_bus = opnd_q;
                wr_ack  = 1'b1;
                valid_d = valid_q | wr_onehot;
                state_d = ST_IDLE;
            end
            ST_SEARCH: begin
                cam_bus = opnd_q;
                // Stale array rows may still match; only valid entries count.
                match_d = cam_match & valid_q;
                state_d = ST_RESULT;
            end
            ST_RESULT: begin
                srch_ack = 1'b1;
                hit_d    = enc_hit;
                raddr_d  = enc_addr;
                multi_d  = enc_multi;
                state_d  = ST_IDLE;
            end
            ST_CLEAR: begin
                cam_rst = 1'b1;
                clr_ack = 1'b1;
                valid_d = '0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign srch_hit   = hit_d;
    assign srch_addr  = raddr_d;
    assign srch_multi = multi_d;
    assign busy       = (state_q != ST_IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            rr_q    <= GNT_WR;
            valid_q <= '0;
            match_q <= '0;
            addr_q  <= '0;
            opnd_q  <= '0;
            hit_q   <= 1'b0;
            raddr_q <= '0;
            multi_q <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            valid_q <= valid_d;
            match_q <= match_d;
            addr_q  <= addr_d;
            opnd_q  <= opnd_d;
            hit_q   <= hit_d;
            raddr_q <= raddr_d;
            multi_q <= multi_d;
        end
    end

endmodule

// File: tb/tb_bcam_controller.sv
// Bench for bcam_controller: behavioural CAM array, table vectors,
// hand-written corner sequences and random ops against a reference model.
module tb_bcam_controller;

    localparam int DEPTH  = 8;
    localparam int WIDTH  = 8;
    localparam int ADDR_W = 3;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              wr_req = 1'b0;
    logic [ADDR_W-1:0] wr_addr = '0;
    logic [WIDTH-1:0]  wr_data = '0;
    logic              wr_ack;
    logic              srch_req = 1'b0;
    logic [WIDTH-1:0]  srch_key = '0;
    logic              srch_ack;
    logic              srch_hit;
    logic [ADDR_W-1:0] srch_addr;
    logic              srch_multi;
    logic              clr_req = 1'b0;
    logic              clr_ack;
    logic              busy;
    logic [DEPTH-1:0]  cam_we;
    logic [WIDTH-1:0]  cam_bus;
    logic              cam_rst;
    logic [DEPTH-1:0]  cam_match;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    bcam_controller #(
        .DEPTH  (DEPTH),
        .WIDTH  (WIDTH),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_req     (wr_req),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_ack     (wr_ack),
        .srch_req   (srch_req),
        .srch_key   (srch_key),
        .srch_ack   (srch_ack),
        .srch_hit   (srch_hit),
        .srch_addr  (srch_addr),
        .srch_multi (srch_multi),
        .clr_req    (clr_req),
        .clr_ack    (clr_ack),
        .busy       (busy),
        .cam_we     (cam_we),
        .cam_bus    (cam_bus),
        .cam_rst    (cam_rst),
        .cam_match  (cam_match)
    );

    // Behavioural CAM array: rows survive controller reset.
    logic [WIDTH-1:0] rows [DEPTH] = '{default: 8'h00};

    always @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (cam_rst) rows[i] <= '0;
            else if (cam_we[i]) rows[i] <= cam_bus;
        end
    end

    always_comb begin
        cam_match = '0;
        for (int i = 0; i < DEPTH; i++) cam_match[i] = (rows[i] == cam_bus);
    end

    // Reference model: which entries hold what, and which are valid.
    bit               ref_valid [DEPTH];
    logic [WIDTH-1:0] ref_mem   [DEPTH];

    function automatic void model_search(input logic [WIDTH-1:0] key,
                                         output bit h, output int a, output bit m);
        int n;
        n = 0;
        a = 0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ref_valid[i] && ref_mem[i] == key) begin
                if (n == 0) a = i;
                n++;
            end
        end
        h = (n > 0);
        m = (n > 1);
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < DEPTH; i++) ref_valid[i] = 1'b0;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        tick();
        rst = 1'b0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_acks", {wr_ack, srch_ack, clr_ack}, 0);
        chk("rst_res", {srch_hit, srch_multi, srch_addr}, 0);
        chk("rst_cam", {cam_we, cam_bus, cam_rst}, 0);
        tick();
        tick();
        rst = 1'b1;
        model_clear();
    endtask

    task automatic op_write(input logic [ADDR_W-1:0] a, input logic [WIDTH-1:0] d);
        int cyc;
        logic [DEPTH-1:0] oh;
        oh = '0;
        oh[a] = 1'b1;
        wr_addr = a;
        wr_data = d;
        wr_req = 1'b1;
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (!wr_ack && cyc < 10);
        chk("wr_latency", wr_ack ? cyc : -1, 1);
        wr_addr = a + 3'd1;
        wr_data = ~d;
        #1;
        chk("wr_cam_we", cam_we, oh);
        chk("wr_cam_bus", cam_bus, d);
        chk("wr_busy", busy, 1);
        wr_req = 1'b0;
        ref_valid[a] = 1'b1;
        ref_mem[a] = d;
        tick();
        chk("wr_we_off", cam_we, 0);
    endtask

    task automatic op_search(input logic [WIDTH-1:0] key,
                             input bit eh, input int ea, input bit em);
        int cyc;
        srch_key = key;
        srch_req = 1'b1;
        tick();
        chk("srch_bus", cam_bus, key);
        chk("srch_we", cam_we, 0);
        srch_key = ~key;
        #1;
        chk("srch_bus_held", cam_bus, key);
        cyc = 1;
        while (!srch_ack && cyc < 10) begin
            tick();
            cyc++;
        end
        chk("srch_latency", srch_ack ? cyc : -1, 2);
        srch_req = 1'b0;
        chk("srch_hit", srch_hit, eh);
        chk("srch_addr", srch_addr, ea);
        chk("srch_multi", srch_multi, em);
        tick();
        chk("srch_ack_pulse", srch_ack, 0);
        chk("srch_res_hold", {srch_hit, srch_multi, srch_addr}, {eh, em, 3'(ea)});
    endtask

    task automatic op_clear();
        int cyc;
        clr_req = 1'b1;
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (!clr_ack && cyc < 10);
        chk("clr_latency", clr_ack ? cyc : -1, 1);
        chk("clr_cam_rst", cam_rst, 1);
        clr_req = 1'b0;
        model_clear();
        tick();
        chk("clr_rst_off", cam_rst, 0);
    endtask

    typedef struct {
        int               kind;
        logic [ADDR_W-1:0] addr;
        logic [WIDTH-1:0]  data;
        bit               hit;
        int               a;
        bit               multi;
    } vec_t;

    vec_t tbl [10];

    initial begin
        string order;
        int    cyc;
        bit    first_s_hit;
        int    first_s_addr;
        bit    seen_s;
        bit    eh, em;
        int    ea;

        for (int i = 0; i < DEPTH; i++) begin
            ref_valid[i] = 1'b0;
            ref_mem[i] = '0;
        end

        tbl[0] = '{1, 3'd0, 8'h00, 1'b0, 0, 1'b0};
        tbl[1] = '{0, 3'd3, 8'h5A, 1'b0, 0, 1'b0};
        tbl[2] = '{1, 3'd0, 8'h5A, 1'b1, 3, 1'b0};
        tbl[3] = '{0, 3'd1, 8'h5A, 1'b0, 0, 1'b0};
        tbl[4] = '{0, 3'd6, 8'h5A, 1'b0, 0, 1'b0};
        tbl[5] = '{1, 3'd0, 8'h5A, 1'b1, 1, 1'b1};
        tbl[6] = '{1, 3'd0, 8'h5B, 1'b0, 0, 1'b0};
        tbl[7] = '{0, 3'd1, 8'h77, 1'b0, 0, 1'b0};
        tbl[8] = '{1, 3'd0, 8'h5A, 1'b1, 3, 1'b1};
        tbl[9] = '{1, 3'd0, 8'h77, 1'b1, 1, 1'b0};

        do_reset();
        for (int i = 0; i < 10; i++) begin
            if (tbl[i].kind == 0) op_write(tbl[i].addr, tbl[i].data);
            else op_search(tbl[i].data, tbl[i].hit, tbl[i].a, tbl[i].multi);
        end

        // Clear beats a pending write.
        clr_req = 1'b1;
        wr_addr = 3'd0;
        wr_data = 8'h33;
        wr_req = 1'b1;
        tick();
        chk("clr_first_ack", clr_ack, 1);
        chk("clr_first_rst", cam_rst, 1);
        chk("clr_first_nowr", wr_ack, 0);
        clr_req = 1'b0;
        model_clear();
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (!wr_ack && cyc < 10);
        chk("clr_then_wr", wr_ack, 1);
        wr_req = 1'b0;
        ref_valid[0] = 1'b1;
        ref_mem[0] = 8'h33;
        tick();
        op_search(8'h5A, 1'b0, 0, 1'b0);
        op_search(8'h33, 1'b1, 0, 1'b0);

        // Both clients held from reset: acks alternate, write first.
        do_reset();
        wr_addr = 3'd2;
        wr_data = 8'h11;
        srch_key = 8'h11;
        wr_req = 1'b1;
        srch_req = 1'b1;
        order = "";
        seen_s = 1'b0;
        first_s_hit = 1'b0;
        first_s_addr = -1;
        for (int c = 0; c < 14; c++) begin
            tick();
            if (wr_ack) order = {order, "W"};
            if (srch_ack) begin
                order = {order, "S"};
                if (!seen_s) begin
                    seen_s = 1'b1;
                    first_s_hit = srch_hit;
                    first_s_addr = srch_addr;
                end
            end
        end
        wr_req = 1'b0;
        srch_req = 1'b0;
        tick();
        tick();
        tick();
        chk("rr_order", (order.len() >= 4 && order.substr(0, 3) == "WSWS") ? 1 : 0, 1);
        chk("rr_s_hit", first_s_hit, 1);
        chk("rr_s_addr", first_s_addr, 2);
        ref_valid[2] = 1'b1;
        ref_mem[2] = 8'h11;

        // Reset during SEARCH abandons it; stale row must not hit afterwards.
        op_write(3'd4, 8'h5A);
        srch_key = 8'h5A;
        srch_req = 1'b1;
        tick();
        chk("mid_busy", busy, 1);
        rst = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_ack", srch_ack, 0);
        srch_req = 1'b0;
        cyc = 0;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (srch_ack) cyc++;
        end
        chk("mid_no_ack", cyc, 0);
        rst = 1'b1;
        model_clear();
        tick();
        op_search(8'h5A, 1'b0, 0, 1'b0);

        // Random traffic against the reference model.
        for (int n = 0; n < 80; n++) begin
            int k;
            int sel;
            logic [WIDTH-1:0] v;
            k = $urandom_range(0, 9);
            sel = $urandom_range(0, 3);
            case (sel)
                0: v = 8'h5A;
                1: v = 8'h3C;
                2: v = 8'hA5;
                default: v = 8'($urandom);
            endcase
            if (k == 0) begin
                op_clear();
            end else if (k < 5) begin
                op_write(3'($urandom_range(0, 7)), v);
            end else begin
                model_search(v, eh, ea, em);
                op_search(v, eh, ea, em);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
